// File: rtl/dllp_demux.sv
// Receive-side DLLP demultiplexer: routes TLP frames into a show-ahead FIFO,
// decodes VC0 UpdateFC frames into a one-cycle credit pulse, and counts dropped frames.
module dllp_demux #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [135:0]       dllp_i,
    input  logic               dllp_valid_i,
    output logic [135:0]       tlp_dllp_o,
    output logic               tlp_valid_o,
    input  logic               tlp_ready_i,
    output logic               fc_valid_o,
    output logic [1:0]         fc_type_o,
    output logic [7:0]         fc_hdr_o,
    output logic [11:0]        fc_data_o,
    output logic               tlp_ovf_o,
    output logic [CNT_W-1:0]   ovf_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [135:0]     r_mem [0:DEPTH-1];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_fc_valid;
    logic [1:0]       r_fc_type;
    logic [7:0]       r_fc_hdr;
    logic [11:0]      r_fc_data;
    logic             r_tlp_ovf;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [7:0] w_type;
    logic       w_is_tlp;
    logic       w_is_fc;
    logic       w_is_drop;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_ovf;

    // Classification: exactly one of TLP / UpdateFC VC0 / drop per valid frame
    always_comb begin
        w_type    = dllp_i[135:128];
        w_is_tlp  = dllp_valid_i && (w_type == 8'h00);
        w_is_fc   = dllp_valid_i && (w_type[3:0] == 4'h0) &&
                    ((w_type[7:4] == 4'h8) || (w_type[7:4] == 4'h9) || (w_type[7:4] == 4'hA));
        w_is_drop = dllp_valid_i && !w_is_tlp && !w_is_fc;
    end

    // A pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop   = !w_empty && tlp_ready_i;
        w_push  = w_is_tlp && (!w_full || w_pop);
        w_ovf   = w_is_tlp && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= dllp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Credit fields hold their last decoded value between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fc_valid <= 1'b0;
            r_fc_type  <= '0;
            r_fc_hdr   <= '0;
            r_fc_data  <= '0;
        end else begin
            r_fc_valid <= w_is_fc;
            if (w_is_fc) begin
                r_fc_type <= w_type[5:4];
                r_fc_hdr  <= dllp_i[127:120];
                r_fc_data <= dllp_i[119:108];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tlp_ovf  <= 1'b0;
            r_ovf_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_ovf) begin
                r_tlp_ovf <= 1'b1;
                if (r_ovf_cnt != '1) begin
                    r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
                end
            end
            if (w_is_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    assign tlp_valid_o = !w_empty;
    assign tlp_dllp_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fc_valid_o  = r_fc_valid;
    assign fc_type_o   = r_fc_type;
    assign fc_hdr_o    = r_fc_hdr;
    assign fc_data_o   = r_fc_data;
    assign tlp_ovf_o   = r_tlp_ovf;
    assign ovf_cnt_o   = r_ovf_cnt;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_dllp_demux.sv
// Scoreboard bench for dllp_demux: expected TLP/credit outputs are queued at stimulus
// time and compared by monitors; directed checks cover latency, overflow, counters, reset.
module tb_dllp_demux;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [135:0]  dllp_i;
    logic          dllp_valid_i;
    logic [135:0]  tlp_dllp_o;
    logic          tlp_valid_o;
    logic          tlp_ready_i;
    logic          fc_valid_o;
    logic [1:0]    fc_type_o;
    logic [7:0]    fc_hdr_o;
    logic [11:0]   fc_data_o;
    logic          tlp_ovf_o;
    logic [CW-1:0] ovf_cnt_o;
    logic [CW-1:0] drop_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    logic [135:0] tlp_q[$];
    logic [21:0]  fc_q[$];

    always #5 clk = ~clk;

    dllp_demux #(.DEPTH(4), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dllp_i       (dllp_i),
        .dllp_valid_i (dllp_valid_i),
        .tlp_dllp_o   (tlp_dllp_o),
        .tlp_valid_o  (tlp_valid_o),
        .tlp_ready_i  (tlp_ready_i),
        .fc_valid_o   (fc_valid_o),
        .fc_type_o    (fc_type_o),
        .fc_hdr_o     (fc_hdr_o),
        .fc_data_o    (fc_data_o),
        .tlp_ovf_o    (tlp_ovf_o),
        .ovf_cnt_o    (ovf_cnt_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change 1ns after posedge; returns at the following negedge
    task automatic cyc(input logic r, input logic v, input logic [135:0] d, input logic rdy);
        @(posedge clk);
        #1;
        rst          = r;
        dllp_valid_i = v;
        dllp_i       = d;
        tlp_ready_i  = rdy;
        @(negedge clk);
    endtask

    function automatic logic [135:0] tf(input int k);
        tf = {8'h00, 32'(32'hC0DE0000 + k), 32'(k * 7 + 1), 64'hDEAD_BEEF_0000_0000 | 64'(k)};
    endfunction

    function automatic logic [135:0] ff(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
        ff = {t, h, d, 108'h5_A5A5_1234};
    endfunction

    always @(negedge clk) begin
        if (tlp_valid_o && tlp_ready_i) begin
            n_pops++;
            if (tlp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tlp_unexpected: got %h expected no frame", tlp_dllp_o);
            end else begin
                chk("tlp_data", tlp_dllp_o, tlp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (fc_valid_o) begin
            if (fc_q.size() == 0) begin
                n_checks++;
                $display("FAIL fc_unexpected: got pulse %h expected none", {fc_type_o, fc_hdr_o, fc_data_o});
            end else begin
                chk("fc_fields", {114'h0, fc_type_o, fc_hdr_o, fc_data_o}, {114'h0, fc_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [135:0] f1;
        int base;
        f1 = {8'h00, 128'hABCD_EF01_2345_6789_0F1E_2D3C_4B5A_6978};
        rst = 1'b1; dllp_valid_i = 1'b0; dllp_i = '0; tlp_ready_i = 1'b0;
        repeat (3) cyc(1, 0, '0, 0);
        cyc(0, 0, '0, 0);
        chk("rst_valid", 136'(tlp_valid_o), 136'h0);
        chk("rst_data", tlp_dllp_o, 136'h0);
        chk("rst_fc", 136'(fc_valid_o), 136'h0);
        chk("rst_ovf", 136'(tlp_ovf_o), 136'h0);
        chk("rst_ovf_cnt", 136'(ovf_cnt_o), 136'h0);
        chk("rst_drop_cnt", 136'(drop_cnt_o), 136'h0);

        // single TLP: latency one cycle, popped, then empty
        tlp_q.push_back(f1);
        cyc(0, 1, f1, 1);
        chk("t1_no_bypass", 136'(tlp_valid_o), 136'h0);
        cyc(0, 0, '0, 1);
        chk("t1_valid", 136'(tlp_valid_o), 136'h1);
        cyc(0, 0, '0, 1);
        chk("t1_empty", 136'(tlp_valid_o), 136'h0);
        chk("t1_zero_data", tlp_dllp_o, 136'h0);

        // UpdateFC NP pulse
        fc_q.push_back({2'd1, 8'h1F, 12'h0C3});
        cyc(0, 1, ff(8'h90, 8'h1F, 12'h0C3), 0);
        chk("t2_not_yet", 136'(fc_valid_o), 136'h0);
        cyc(0, 0, '0, 0);
        chk("t2_pulse", 136'(fc_valid_o), 136'h1);
        cyc(0, 0, '0, 0);
        chk("t2_pulse_end", 136'(fc_valid_o), 136'h0);
        chk("t2_hdr_hold", 136'(fc_hdr_o), 136'h1F);

        // back-to-back UpdateFC
        fc_q.push_back({2'd0, 8'h22, 12'hFFF});
        cyc(0, 1, ff(8'h80, 8'h22, 12'hFFF), 0);
        fc_q.push_back({2'd2, 8'h05, 12'h123});
        cyc(0, 1, ff(8'hA0, 8'h05, 12'h123), 0);
        chk("b2b_first", 136'(fc_valid_o), 136'h1);
        cyc(0, 0, '0, 0);
        chk("b2b_second", 136'(fc_valid_o), 136'h1);
        cyc(0, 0, '0, 0);
        chk("b2b_end", 136'(fc_valid_o), 136'h0);

        // fill past full with consumer stalled
        for (int k = 0; k < 5; k++) begin
            if (k < 4) tlp_q.push_back(tf(k));
            cyc(0, 1, tf(k), 0);
        end
        cyc(0, 0, '0, 0);
        chk("t3_ovf", 136'(tlp_ovf_o), 136'h1);
        chk("t3_ovf_cnt", 136'(ovf_cnt_o), 136'h1);
        chk("t3_head", tlp_dllp_o, tf(0));
        cyc(0, 0, '0, 0);
        chk("t3_head_stable", tlp_dllp_o, tf(0));
        chk("t3_no_drop", 136'(drop_cnt_o), 136'h0);

        // full with simultaneous push+pop, 2*DEPTH times, then drain
        base = n_pops;
        for (int k = 5; k < 13; k++) begin
            tlp_q.push_back(tf(k));
            cyc(0, 1, tf(k), 1);
        end
        repeat (6) cyc(0, 0, '0, 1);
        chk("t4_pops", 136'(n_pops - base), 136'd12);
        chk("t4_ovf_cnt", 136'(ovf_cnt_o), 136'h1);
        chk("t4_q_empty", 136'(tlp_q.size()), 136'h0);
        chk("t4_valid", 136'(tlp_valid_o), 136'h0);

        // drops and saturation
        cyc(0, 1, ff(8'h81, 8'h01, 12'h001), 1);
        cyc(0, 1, ff(8'h40, 8'h02, 12'h002), 1);
        cyc(0, 1, ff(8'hB0, 8'h03, 12'h003), 1);
        cyc(0, 0, '0, 1);
        chk("t5_drop3", 136'(drop_cnt_o), 136'h3);
        chk("t5_no_push", 136'(tlp_valid_o), 136'h0);
        repeat (13) cyc(0, 1, ff(8'h91, 8'h04, 12'h004), 1);
        cyc(0, 0, '0, 1);
        chk("t5_saturate", 136'(drop_cnt_o), 136'hF);

        // reset with queued entries and an UpdateFC in the same cycle
        for (int k = 20; k < 23; k++) cyc(0, 1, tf(k), 0);
        cyc(0, 0, '0, 0);
        chk("t6_pre_valid", 136'(tlp_valid_o), 136'h1);
        cyc(1, 1, ff(8'hA0, 8'h77, 12'h777), 0);
        cyc(0, 0, '0, 0);
        chk("t6_valid", 136'(tlp_valid_o), 136'h0);
        chk("t6_data", tlp_dllp_o, 136'h0);
        chk("t6_fc_valid", 136'(fc_valid_o), 136'h0);
        chk("t6_fc_fields", 136'({fc_type_o, fc_hdr_o, fc_data_o}), 136'h0);
        chk("t6_ovf", 136'(tlp_ovf_o), 136'h0);
        chk("t6_ovf_cnt", 136'(ovf_cnt_o), 136'h0);
        chk("t6_drop_cnt", 136'(drop_cnt_o), 136'h0);
        cyc(0, 0, '0, 0);
        chk("t6_no_pulse", 136'(fc_valid_o), 136'h0);

        chk("end_tlp_q", 136'(tlp_q.size()), 136'h0);
        chk("end_fc_q", 136'(fc_q.size()), 136'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
